// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - miss-handling FSM for a write-back cache: victim writeback, fetch, fill
// Hit/miss counters saturate; every output is held low while rst is asserted.
module cache_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  hit,
   input  logic                  victim_dirty,
   input  logic [ADDR_WIDTH-1:0] victim_addr,
   input  logic [DATA_WIDTH-1:0] victim_data,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  fill_en,
   output logic [ADDR_WIDTH-1:0] fill_addr,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
   logic [ADDR_WIDTH-1:0] vic_addr_q, vic_addr_d;
   logic [DATA_WIDTH-1:0] vic_data_q, vic_data_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [31:0]           hit_count_q, hit_count_d;
   logic [31:0]           miss_count_q, miss_count_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         miss_addr_q  <= '0;
         vic_addr_q   <= '0;
         vic_data_q   <= '0;
         rdata_q      <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         miss_addr_q  <= miss_addr_d;
         vic_addr_q   <= vic_addr_d;
         vic_data_q   <= vic_data_d;
         rdata_q      <= rdata_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      miss_addr_d  = miss_addr_q;
      vic_addr_d   = vic_addr_q;
      vic_data_d   = vic_data_q;
      rdata_d      = rdata_q;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      stall        = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      fill_en      = 1'b0;
      fill_addr    = '0;
      fill_data    = '0;

      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               if (hit) begin
                  if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
               end else begin
                  // Miss is flagged in the detect cycle so the pipeline freezes immediately.
                  stall       = 1'b1;
                  miss_addr_d = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                  if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
                  if (victim_dirty) begin
                     vic_addr_d = {victim_addr[ADDR_WIDTH-1:2], 2'b00};
                     vic_data_d = victim_data;
                     state_d    = WRITEBACK;
                  end else begin
                     state_d    = FETCH;
                  end
               end
            end
         end
         WRITEBACK: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = vic_addr_q;
            mem_wdata = vic_data_q;
            if (mem_ready) state_d = FETCH;
         end
         FETCH: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = miss_addr_q;
            if (mem_ready) begin
               rdata_d = mem_rdata;
               state_d = FILL;
            end
         end
         FILL: begin
            stall     = 1'b1;
            fill_en   = 1'b1;
            fill_addr = miss_addr_q;
            fill_data = rdata_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The IDLE miss stall is combinational from cpu inputs, so gate it during reset too.
      if (!rst) begin
         stall     = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         fill_en   = 1'b0;
         fill_addr = '0;
         fill_data = '0;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed scoreboard bench for cache_controller
module tb_cache_controller;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, hit, victim_dirty, mem_ready;
    logic [AW-1:0] cpu_addr, victim_addr;
    logic [DW-1:0] victim_data, mem_rdata;
    logic          stall, mem_req, mem_we, fill_en;
    logic [AW-1:0] mem_addr, fill_addr;
    logic [DW-1:0] mem_wdata, fill_data;
    logic [31:0]   hit_count, miss_count;

    typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } mem_tx_t;
    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } fill_t;

    mem_tx_t mem_exp_q[$];
    fill_t   fill_exp_q[$];
    mem_tx_t e_tx, prev_bus;
    fill_t   e_fill;
    bit      prev_pend = 1'b0;

    int checks = 0, errors = 0;
    int stall_cycles = 0, mem_req_cycles = 0, fill_cycles = 0;
    logic [31:0] exp_hits = 32'd0, exp_misses = 32'd0;

    bit            ready_always = 1'b0;
    int            ready_delay = 0;
    logic [DW-1:0] rd_word = '0;

    cache_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .hit(hit),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .fill_en(fill_en),
        .fill_addr(fill_addr), .fill_data(fill_data), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    initial begin
        int   wait_cnt;
        logic prev_req;
        wait_cnt  = 0;
        prev_req  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_ready && prev_req) wait_cnt = 0;
            if (ready_always) begin
                mem_ready = 1'b1;
                mem_rdata = rd_word;
            end else if (mem_req) begin
                if (wait_cnt >= ready_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd_word;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = ~rd_word;
                    wait_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = ~rd_word;
                wait_cnt  = 0;
            end
            prev_req = mem_req;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (stall)   stall_cycles++;
            if (mem_req) mem_req_cycles++;
            if (fill_en) fill_cycles++;
            if (!mem_req) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== '0) begin
                    errors++;
                    $error("FAIL mem_idle_zero");
                end
            end
            if (prev_pend) begin
                checks++;
                if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, prev_bus}) begin
                    errors++;
                    $error("FAIL mem_stable");
                end
            end
            if (mem_req && mem_ready) begin
                checks++;
                if (mem_exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL mem_tx_expected");
                end else begin
                    e_tx = mem_exp_q.pop_front();
                    checks++;
                    if ({mem_we, mem_addr, mem_wdata} !== e_tx) begin
                        errors++;
                        $error("FAIL mem_tx observed %0h expected %0h", {mem_we, mem_addr, mem_wdata}, e_tx);
                    end
                end
            end
            if (fill_en) begin
                checks++;
                if (mem_req !== 1'b0) begin
                    errors++;
                    $error("FAIL fill_no_memreq");
                end
                checks++;
                if (fill_exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL fill_expected");
                end else begin
                    e_fill = fill_exp_q.pop_front();
                    checks++;
                    if ({fill_addr, fill_data} !== e_fill) begin
                        errors++;
                        $error("FAIL fill observed %0h expected %0h", {fill_addr, fill_data}, e_fill);
                    end
                end
            end
            prev_pend = mem_req && !mem_ready;
            prev_bus  = {mem_we, mem_addr, mem_wdata};
        end else begin
            prev_pend = 1'b0;
        end
    end

    task automatic do_miss(input logic [AW-1:0] addr, input logic dirty,
                           input logic [AW-1:0] vaddr, input logic [DW-1:0] vdata,
                           input logic [DW-1:0] word, input int delay, input bit churn,
                           input int exp_stall);
        mem_tx_t t;
        fill_t   f;
        bit      done;
        @(posedge clk);
        #1;
        if (dirty) begin
            t.we = 1'b1; t.addr = {vaddr[AW-1:2], 2'b00}; t.data = vdata;
            mem_exp_q.push_back(t);
        end
        t.we = 1'b0; t.addr = {addr[AW-1:2], 2'b00}; t.data = '0;
        mem_exp_q.push_back(t);
        f.addr = {addr[AW-1:2], 2'b00}; f.data = word;
        fill_exp_q.push_back(f);
        ready_delay = delay;
        rd_word     = word;
        cpu_req = 1'b1; hit = 1'b0; cpu_addr = addr;
        victim_dirty = dirty; victim_addr = vaddr; victim_data = vdata;
        stall_cycles = 0;
        fill_cycles  = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $error("FAIL miss_stall_comb");
        end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            hit = 1'b1;
            if (churn && mem_req) begin
                cpu_addr     = $urandom;
                victim_addr  = $urandom;
                victim_data  = $urandom;
                victim_dirty = 1'($urandom_range(0, 1));
                hit          = 1'($urandom_range(0, 1));
            end else begin
                cpu_addr = addr;
            end
            @(negedge clk);
            done = !stall;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $error("FAIL miss_done_in_budget");
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        hit     = 1'b0;
        exp_misses = sat_inc(exp_misses);
        exp_hits   = sat_inc(exp_hits);
        @(negedge clk);
        checks++;
        if (stall_cycles != exp_stall) begin
            errors++;
            $error("FAIL miss_stall_cycles observed %0d expected %0d", stall_cycles, exp_stall);
        end
        checks++;
        if (fill_cycles != 1) begin
            errors++;
            $error("FAIL miss_fill_once observed %0d", fill_cycles);
        end
        checks++;
        if (hit_count !== exp_hits) begin
            errors++;
            $error("FAIL miss_hit_count observed %0h expected %0h", hit_count, exp_hits);
        end
        checks++;
        if (miss_count !== exp_misses) begin
            errors++;
            $error("FAIL miss_miss_count observed %0h expected %0h", miss_count, exp_misses);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cpu_req = 1'b1; hit = 1'b0; cpu_addr = 32'h46;
        victim_dirty = 1'b0; victim_addr = '0; victim_data = '0;
        #12;
        checks++;
        if (stall !== 1'b0) begin errors++; $error("FAIL reset_stall"); end
        checks++;
        if (mem_req !== 1'b0) begin errors++; $error("FAIL reset_mem_req"); end
        checks++;
        if (fill_en !== 1'b0) begin errors++; $error("FAIL reset_fill_en"); end
        checks++;
        if (hit_count !== 32'd0) begin errors++; $error("FAIL reset_hit_count"); end
        checks++;
        if (miss_count !== 32'd0) begin errors++; $error("FAIL reset_miss_count"); end

        @(posedge clk);
        #1;
        rst = 1'b1;
        ready_always = 1'b1;
        stall_cycles = 0;
        mem_req_cycles = 0;
        cpu_req = 1'b1; hit = 1'b1; cpu_addr = 32'h10;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (stall !== 1'b0) begin errors++; $error("FAIL hit_stall"); end
            @(posedge clk);
            #1;
        end
        cpu_req = 1'b0;
        for (int i = 0; i < 5; i++) exp_hits = sat_inc(exp_hits);
        repeat (2) @(negedge clk);
        checks++;
        if (hit_count !== exp_hits) begin errors++; $error("FAIL hit_count_5 observed %0h", hit_count); end
        checks++;
        if (miss_count !== exp_misses) begin errors++; $error("FAIL hit_miss_count observed %0h", miss_count); end
        checks++;
        if (mem_req_cycles != 0) begin errors++; $error("FAIL hit_no_mem_req"); end
        checks++;
        if (stall_cycles != 0) begin errors++; $error("FAIL hit_no_stall"); end

        do_miss(32'h0000_0046, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 3);
        ready_always = 1'b0;
        do_miss(32'h0000_1008, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'hCAFE_F00D, 2, 1'b0, 8);
        do_miss(32'h0000_2ABF, 1'b1, 32'h0000_02F3, 32'hA5A5_5A5A, 32'h0BAD_F00D, 0, 1'b0, 4);
        do_miss(32'h0000_3301, 1'b0, 32'h0000_0077, 32'h0000_0001, 32'h600D_CAFE, 3, 1'b1, 6);

        @(posedge clk);
        #1;
        ready_delay = 100;
        fill_cycles = 0;
        cpu_req = 1'b1; hit = 1'b0; cpu_addr = 32'h500; victim_dirty = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $error("FAIL abort_fetch_req"); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $error("FAIL abort_mem_req"); end
        checks++;
        if (stall !== 1'b0) begin errors++; $error("FAIL abort_stall"); end
        checks++;
        if (fill_en !== 1'b0) begin errors++; $error("FAIL abort_fill_en"); end
        checks++;
        if (hit_count !== 32'd0) begin errors++; $error("FAIL abort_hit_count"); end
        checks++;
        if (miss_count !== 32'd0) begin errors++; $error("FAIL abort_miss_count"); end
        exp_hits = 32'd0;
        exp_misses = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ready_delay = 0;
        cpu_req = 1'b1; hit = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        exp_hits = sat_inc(exp_hits);
        repeat (3) @(negedge clk);
        checks++;
        if (fill_cycles != 0) begin errors++; $error("FAIL abort_no_fill"); end
        checks++;
        if (hit_count !== exp_hits) begin errors++; $error("FAIL post_reset_hit observed %0h", hit_count); end

        @(posedge clk);
        #1;
        force dut.hit_count_q = 32'hFFFF_FFFD;
        force dut.miss_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.hit_count_q;
        release dut.miss_count_q;
        exp_hits = 32'hFFFF_FFFD;
        exp_misses = 32'hFFFF_FFFE;
        cpu_req = 1'b1; hit = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        cpu_req = 1'b0;
        for (int i = 0; i < 5; i++) exp_hits = sat_inc(exp_hits);
        @(negedge clk);
        checks++;
        if (hit_count !== exp_hits) begin errors++; $error("FAIL hit_saturate observed %0h", hit_count); end
        ready_always = 1'b1;
        do_miss(32'h0000_0804, 1'b0, 32'h0, 32'h0, 32'h1111_2222, 0, 1'b0, 3);
        do_miss(32'h0000_0C08, 1'b0, 32'h0, 32'h0, 32'h3333_4444, 0, 1'b0, 3);
        checks++;
        if (miss_count !== 32'hFFFF_FFFF) begin errors++; $error("FAIL miss_saturate observed %0h", miss_count); end

        checks++;
        if (mem_exp_q.size() != 0) begin errors++; $error("FAIL mem_queue_drained"); end
        checks++;
        if (fill_exp_q.size() != 0) begin errors++; $error("FAIL fill_queue_drained"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the word width of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 32, sets the width of all address ports.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; active when 0.
REQ-005 cpu_req  input  1  a load or store is presented to the cache this cycle.
REQ-006 cpu_addr  input  ADDR_WIDTH  byte address of the access.
REQ-007 hit  input  1  cache lookup result for cpu_addr, combinational from the cache.
REQ-008 victim_dirty  input  1  the LRU way of the indexed set is valid and dirty.
REQ-009 victim_addr  input  ADDR_WIDTH  reconstructed address (tag, set) of the victim word.
REQ-010 victim_data  input  DATA_WIDTH  victim word to be written back.
REQ-011 mem_ready  input  1  main memory accepts/completes the current request this cycle.
REQ-012 mem_rdata  input  DATA_WIDTH  read data, valid when mem_ready is 1 on a read.
REQ-013 stall  output  1  freeze pipeline; the access must be replayed.
REQ-014 mem_req  output  1  request to main memory.
REQ-015 mem_we  output  1  1 = writeback, 0 = fetch.
REQ-016 mem_addr  output  ADDR_WIDTH  word-aligned memory address.
REQ-017 mem_wdata  output  DATA_WIDTH  writeback data.
REQ-018 fill_en  output  1  one-cycle strobe: write fill_data/fill_addr into the LRU way, set valid, clear dirty, flip LRU.
REQ-019 fill_addr  output  ADDR_WIDTH  word-aligned address of the fill.
REQ-020 fill_data  output  DATA_WIDTH  word returned by memory.
REQ-021 hit_count  output  32  number of hit accesses.
REQ-022 miss_count  output  32  number of misses serviced.

Function
REQ-023 FSM states SHALL be IDLE, WRITEBACK, FETCH, FILL.
REQ-024 IDLE: cpu_req&&hit -> stay IDLE, stall=0, hit_count+1.
REQ-025 IDLE: cpu_req&&!hit -> stall=1 combinationally that same cycle; latch cpu_addr[ADDR_WIDTH-1:2]<<2 as miss address; miss_count+1; next = WRITEBACK if victim_dirty, else FETCH.
REQ-026 On a dirty miss, victim_addr (low 2 bits zeroed) and victim_data SHALL be latched in the same cycle as the miss address.
REQ-027 WRITEBACK: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched victim; on mem_ready -> FETCH.
REQ-028 FETCH: mem_req=1, mem_we=0, mem_addr = latched miss address; on mem_ready latch mem_rdata -> FILL.
REQ-029 FILL: fill_en=1 for exactly one cycle, fill_addr = latched miss address, fill_data = latched read word; -> IDLE.
REQ-030 stall SHALL be 1 in WRITEBACK, FETCH and FILL regardless of other inputs.
REQ-031 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable from assertion until the cycle mem_ready=1 (inclusive).
REQ-032 mem_req SHALL be 0 in IDLE and FILL; mem_we, mem_addr, mem_wdata SHALL be 0 whenever mem_req=0.
REQ-033 cpu_addr, hit, victim_* changes while not in IDLE SHALL be ignored.
REQ-034 A replayed access after FILL is evaluated in IDLE like any other; its hit increments hit_count.
REQ-035 mem_ready while mem_req=0 SHALL be ignored.
REQ-036 Clean-miss latency with mem_ready held 1: stall high 3 cycles (IDLE-detect, FETCH, FILL); dirty miss: 4 cycles; each mem_ready=0 cycle adds one.
REQ-037 hit_count and miss_count SHALL saturate at 32'hFFFF_FFFF, never wrap.
REQ-038 cpu_req=0 in IDLE: no counter change, stall=0, no state change.

Reset
REQ-039 rst=0 SHALL immediately force state IDLE, all outputs 0, counters 0, latched registers 0, independent of clk.
REQ-040 Reset during WRITEBACK/FETCH SHALL drop mem_req in the same cycle; no fill_en is issued for the aborted miss.
REQ-041 After rst deasserts, the first rising edge SHALL behave as IDLE.

Verification
REQ-042 Hit: cpu_req=1, hit=1 for 5 cycles -> stall=0 throughout, hit_count=5, mem_req never 1.
REQ-043 Clean miss: cpu_addr=0x0000_0046, hit=0, victim_dirty=0, mem_ready=1, mem_rdata=0xDEADBEEF -> mem_addr=0x44 read, fill_en one cycle with fill_data=0xDEADBEEF, stall 3 cycles, miss_count=1.
REQ-044 Dirty miss: victim_addr=0x100, victim_data=0x12345678, mem_ready delayed 2 cycles per request -> write 0x12345678 to 0x100 then read of miss address, each held stable until ready, stall 8 cycles.
REQ-045 Reset mid-FETCH: drive rst=0 with mem_ready=0 -> mem_req=0 and stall=0 asynchronously, no fill_en, counters 0.
REQ-046 Saturation: force 2^32+3 hit accesses (or preload via forced state) -> hit_count holds 32'hFFFF_FFFF.
REQ-047 Input churn: toggle cpu_addr and victim_* during FETCH -> mem_addr and fill_addr remain the latched miss address.
